// File: rtl/arb_pkg.sv
// Shared types and widths for the two-requester memory arbiter.
package arb_pkg;
  localparam int unsigned ADR_W          = 6;
  localparam int unsigned DAT_W          = 8;
  localparam int unsigned ACC_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_e;
endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);
  always_comb begin
    win = '0;
    // last == 1 means requester 1 was served most recently, so 0 wins a tie
    if (req[0] && (!req[1] || last)) begin
      win[0] = 1'b1;
    end else if (req[1]) begin
      win[1] = 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU (0) and program loader (1) onto a single memory port with
// a fixed-length access window and a one-cycle completion pulse.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ACC_CYCLES = ACC_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             rd0,
  input  logic             rd1,
  input  logic             wr0,
  input  logic             wr1,
  input  logic [ADR_W-1:0] adr0,
  input  logic [ADR_W-1:0] adr1,
  input  logic [DAT_W-1:0] wdata0,
  input  logic [DAT_W-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [DAT_W-1:0] rdata,
  output logic [ADR_W-1:0] adr_bus,
  output logic             rd_mem,
  output logic             wr_mem,
  inout  tri logic [DAT_W-1:0] data_bus
);
  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             rd_mem_q, rd_mem_d;
  logic             wr_mem_q, wr_mem_d;
  logic             rd_q, rd_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] wdata_q, wdata_d;
  logic [DAT_W-1:0] rdata_q, rdata_d;
  logic             last_q, last_d;

  logic [1:0]       win;
  logic             rd_sel;
  logic             wr_sel;
  logic [ADR_W-1:0] adr_sel;
  logic [DAT_W-1:0] wdata_sel;

  arb_rr_pick u_pick (
    .req  ({req1, req0}),
    .last (last_q),
    .win  (win)
  );

  always_comb begin
    rd_sel    = win[1] ? rd1    : rd0;
    wr_sel    = win[1] ? wr1    : wr0;
    adr_sel   = win[1] ? adr1   : adr0;
    wdata_sel = win[1] ? wdata1 : wdata0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rd_mem_d = rd_mem_q;
    wr_mem_d = wr_mem_q;
    rd_d     = rd_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    last_d   = last_q;

    unique case (state_q)
      IDLE: begin
        if (|win) begin
          state_d  = ACCESS;
          cnt_d    = CNT_LOAD;
          gnt_d    = win;
          rd_d     = rd_sel;
          adr_d    = adr_sel;
          wdata_d  = wdata_sel;
          rd_mem_d = rd_sel;
          // read takes precedence when both directions are requested
          wr_mem_d = wr_sel & ~rd_sel;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          rd_mem_d = 1'b0;
          wr_mem_d = 1'b0;
          done_d   = gnt_q;
          if (rd_q) begin
            rdata_d = data_bus;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = gnt_q[1];
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rd_mem_q <= 1'b0;
      wr_mem_q <= 1'b0;
      rd_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rd_mem_q <= rd_mem_d;
      wr_mem_q <= wr_mem_d;
      rd_q     <= rd_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      last_q   <= last_d;
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign done0    = done_q[0];
  assign done1    = done_q[1];
  assign rd_mem   = rd_mem_q;
  assign wr_mem   = wr_mem_q;
  assign adr_bus  = adr_q;
  assign rdata    = rdata_q;
  // bus release follows wr_mem_q, which reset clears asynchronously
  assign data_bus = wr_mem_q ? wdata_q : 'z;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected transfers,
// a negedge monitor checks strobes, bus data and completions against them.
module tb_mem_arbiter;
  localparam int ACC = 2;

  typedef struct {
    bit         who;
    bit         is_rd;
    bit         is_wr;
    logic [5:0] adr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       rd0 = 1'b0, rd1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [5:0] adr0 = '0, adr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, done0, done1, rd_mem, wr_mem;
  logic [7:0] rdata;
  logic [5:0] adr_bus;
  wire  [7:0] data_bus;

  logic [7:0] mem [64] = '{5: 8'hA7, 16: 8'h42, 32: 8'h5E, default: 8'h00};

  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ACC_CYCLES(ACC)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .rd0      (rd0),
    .rd1      (rd1),
    .wr0      (wr0),
    .wr1      (wr1),
    .adr0     (adr0),
    .adr1     (adr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .rdata    (rdata),
    .adr_bus  (adr_bus),
    .rd_mem   (rd_mem),
    .wr_mem   (wr_mem),
    .data_bus (data_bus)
  );

  assign data_bus = rd_mem ? mem[adr_bus] : 8'bz;

  always @(posedge clk) begin
    if (wr_mem) mem[adr_bus] <= data_bus;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor state
  int   cyc = 0, last_rise = 0, rise_gap = 0;
  int   gnt_cycles = 0, rd_cycles = 0, wr_cycles = 0;
  bit   gnt_prev = 0, done_prev = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      q.delete();
      gnt_cycles = 0; rd_cycles = 0; wr_cycles = 0;
      gnt_prev = 0; done_prev = 0;
    end else begin
      if ((gnt0 || gnt1) && !gnt_prev) begin
        rise_gap = cyc - last_rise;
        last_rise = cyc;
        gnt_cycles = 0; rd_cycles = 0; wr_cycles = 0;
      end
      if (gnt0 || gnt1) begin
        gnt_cycles++;
        chk("one_grant", int'(gnt0 & gnt1), 0);
      end
      if (rd_mem) rd_cycles++;
      if (wr_mem) wr_cycles++;
      if ((rd_mem || wr_mem) && q.size() > 0) chk("adr_bus", adr_bus, q[0].adr);
      if (wr_mem && q.size() > 0) chk("data_bus_wr", data_bus, q[0].wdata);
      if (done0 || done1) begin
        done_cnt++;
        chk("done_width", int'(done_prev), 0);
        chk("done_expected", int'(q.size() > 0), 1);
        if (q.size() > 0 && !done_prev) begin
          e = q.pop_front();
          chk("done_who", {done1, done0}, e.who ? 2 : 1);
          chk("rdata", rdata, e.rdata);
          chk("gnt_len", gnt_cycles, ACC + 1);
          chk("rd_len", rd_cycles, e.is_rd ? ACC : 0);
          chk("wr_len", wr_cycles, (e.is_wr && !e.is_rd) ? ACC : 0);
          if (e.gap != 0) chk("grant_gap", rise_gap, e.gap);
        end
      end
      gnt_prev  = gnt0 | gnt1;
      done_prev = done0 | done1;
    end
  end

  task automatic push(input bit who, input bit rd, input bit wr, input logic [5:0] adr,
                      input logic [7:0] wd, input logic [7:0] exp_rd, input int gap);
    exp_t e;
    e.who = who; e.is_rd = rd; e.is_wr = wr; e.adr = adr;
    e.wdata = wd; e.rdata = exp_rd; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic wait_dones(input int n);
    int target;
    int t;
    target = done_cnt + n;
    t = 0;
    while (done_cnt < target && t < 40) begin
      @(negedge clk); #1;
      t++;
    end
    chk("done_count", done_cnt, target);
  endtask

  task automatic set_req(input bit who, input bit rd, input bit wr,
                         input logic [5:0] adr, input logic [7:0] wd);
    if (!who) begin
      req0 = 1; rd0 = rd; wr0 = wr; adr0 = adr; wdata0 = wd;
    end else begin
      req1 = 1; rd1 = rd; wr1 = wr; adr1 = adr; wdata1 = wd;
    end
  endtask

  // called at posedge+1 in IDLE; returns at posedge+1 in IDLE
  task automatic issue(input bit who, input bit rd, input bit wr, input logic [5:0] adr,
                       input logic [7:0] wd, input logic [7:0] exp_rd, input bit drop_early);
    push(who, rd, wr, adr, wd, exp_rd, 0);
    set_req(who, rd, wr, adr, wd);
    if (drop_early) begin
      @(posedge clk); #1;
      req0 = 0; req1 = 0; rd0 = 0; rd1 = 0; wr0 = 1; wr1 = 1;
      adr0 = ~adr; adr1 = ~adr; wdata0 = 8'hEE; wdata1 = 8'hEE;
    end
    wait_dones(1);
    req0 = 0; req1 = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_strobes", {rd_mem, wr_mem}, 0);
    chk("rst_adr_bus", adr_bus, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    @(posedge clk); #1;

    // both requesters from reset: 0 first, then strict alternation
    push(0, 1, 0, 6'h05, 8'h00, 8'hA7, 0);
    push(1, 1, 0, 6'h10, 8'h00, 8'h42, ACC + 2);
    push(0, 1, 0, 6'h05, 8'h00, 8'hA7, ACC + 2);
    push(1, 1, 0, 6'h10, 8'h00, 8'h42, ACC + 2);
    set_req(0, 1, 0, 6'h05, 8'h00);
    set_req(1, 1, 0, 6'h10, 8'h00);
    wait_dones(4);
    req0 = 0; req1 = 0;
    @(posedge clk); #1;

    issue(1, 0, 1, 6'h3F, 8'h3C, 8'h42, 0);   // write, rdata held
    issue(0, 1, 0, 6'h3F, 8'h00, 8'h3C, 0);   // read back the write
    issue(0, 1, 1, 6'h20, 8'hFF, 8'h5E, 0);   // rd+wr: read only
    issue(1, 0, 0, 6'h01, 8'h00, 8'h5E, 0);   // no-op, rdata held
    issue(0, 1, 0, 6'h05, 8'h00, 8'hA7, 1);   // inputs dropped after sampling

    // reset during the first access cycle of a write
    set_req(1, 0, 1, 6'h02, 8'h99);
    @(posedge clk); #2;
    chk("wr_mem_pre_rst", wr_mem, 1);
    req1 = 0; wr1 = 0; reset = 1;
    #1;
    chk("wr_mem_async_rst", wr_mem, 0);
    chk("rd_mem_async_rst", rd_mem, 0);
    chk("gnt_async_rst", {gnt1, gnt0}, 0);
    begin
      int base;
      base = done_cnt;
      repeat (2) @(negedge clk);
      reset = 0;
      repeat (3) @(negedge clk);
      chk("no_done_after_rst", done_cnt, base);
      chk("rdata_after_rst", rdata, 0);
    end
    @(posedge clk); #1;

    push(0, 1, 0, 6'h20, 8'h00, 8'h5E, 0);
    push(1, 1, 0, 6'h3F, 8'h00, 8'h3C, ACC + 2);
    set_req(0, 1, 0, 6'h20, 8'h00);
    set_req(1, 1, 0, 6'h3F, 8'h00);
    wait_dones(1);
    req0 = 0;
    wait_dones(1);
    req1 = 0;
    repeat (3) @(negedge clk);

    chk("queue_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
